pixread: RTL and testbench
==========================

// Module: pixread
// PURPOSE
//  Reader side of the pixel line buffer (4096 x 16, synchronous-read RAM) that pixcopy fills.
//  On a start pulse it reads every captured RGB565 word in address order.
//  It streams the words to the detector over a valid/ready interface, with unpacked R/G/B fields and a colour-threshold hit flag.
//  It sits between the line-buffer read port and the ball-detection logic.
// PARAMETERS
//  R_MIN  5'd20  hit requires red   >= R_MIN
//  G_MAX  6'd24  hit requires green <= G_MAX
//  B_MAX  5'd12  hit requires blue  <= B_MAX
// PORTS
//  clk        in   1   system clock, all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   1-cycle pulse: begin reading buffer (ignored while busy)
//  end_addr   in   12  last written address (writer's final wraddr), sampled on accepted start
//  rd_en      out  1   RAM read enable
//  rd_addr    out  12  RAM read address
//  rd_data    in   16  RAM read data, valid exactly 1 cycle after rd_en
//  out_valid  out  1   output word available
//  out_ready  in   1   downstream accepts word when out_valid & out_ready
//  out_pix    out  16  raw word {R[4:0],G[5:0],B[4:0]}
//  out_r/out_g/out_b out 5/6/5  unpacked fields of out_pix
//  out_hit    out  1   R>=R_MIN && G<=G_MAX && B<=B_MAX for out_pix
//  out_idx    out  12  buffer address the word came from
//  out_last   out  1   word is the one at end_addr
//  busy       out  1   high from accepted start until done
//  done       out  1   1-cycle pulse when final word has been accepted
// BEHAVIOUR
//  Reset: out_valid=0, busy=0, done=0, rd_en=0, rd_addr=0, output FIFO empty, in-flight count 0.
//  Address convention: address 0 unused; valid words at 1..end_addr inclusive; end_addr==0 means empty buffer.
//  FSM IDLE -> READ -> DRAIN -> IDLE.
//   IDLE: start=1 latches end_addr and sets busy=1 next cycle.
//     If end_addr==0: busy stays 0, done pulses the cycle after start, and no reads are issued.
//     Otherwise go to READ with next address = 1.
//   READ: issue rd_en with rd_addr = next address when (fifo_count + inflight) < 4, then increment next address.
//     After issuing address end_addr, go to DRAIN.
//   DRAIN: no reads. When FIFO is empty, inflight==0 and the last word was accepted: done=1 for 1 cycle, busy=0, go to IDLE.
//  Read data return: rd_data is pushed into a 4-entry output FIFO in the cycle it is valid.
//   Each entry stores its idx and a last flag (idx==end_addr).
//   The credit rule guarantees the FIFO never overflows; any overflow is a design error.
//  Output fields are driven combinationally from the FIFO head; out_valid = FIFO non-empty.
//   Head is popped on out_valid & out_ready; a push and a pop in the same cycle leave the count unchanged.
//  Latency: start at edge E0 -> rd_en high in cycle E0+1 -> first out_valid in cycle E0+3.
//  Throughput: with out_ready held high, one word per cycle sustained, with no bubbles after the first.
//  Backpressure: when out_ready is low, issue stops within the 4-entry credit. Data is never dropped or duplicated.
//  start while busy: ignored, end_addr not re-sampled.
//  end_addr==4095: reads 1..4095 and rd_addr never wraps to 0.
//  rst mid-operation: all state returns to reset values next cycle. In-flight RAM data is discarded and done is not pulsed.
// TESTING
//  1 end_addr=5, RAM[a]=a*16'h1111, out_ready=1 -> out_pix 1111,2222,..,5555 on 5 consecutive cycles.
//    First out_valid at E0+3; out_last only on idx 5; done 1 cycle after last accept.
//  2 end_addr=100, out_ready random 50% -> all 100 words in order, idx 1..100, no loss or duplicates.
//    Never more than 4 reads outstanding beyond consumed words.
//  3 end_addr=0 -> no rd_en, done pulses at E0+1, busy stays 0.
//  4 RAM word 16'hA000 (R=20,G=0,B=0) -> out_hit=1; word 16'h9800 (R=19) -> out_hit=0; word 16'hA320 (G=25) -> out_hit=0.
//  5 second start pulse mid-read with a different end_addr -> ignored; original count completes.
//  6 rst asserted after 3 of 10 words -> next cycle out_valid=0, busy=0, rd_en=0.
//    A new start with end_addr=2 then reads addresses 1,2 correctly.

Source files
------------

// File: rtl/pixread.sv
// Streams the captured RGB565 words of the pixel line buffer (addresses 1..end_addr) to the
// ball detector over valid/ready, with unpacked colour fields and a threshold hit flag.
module pixread #(
   parameter logic [4:0] R_MIN = 5'd20,
   parameter logic [5:0] G_MAX = 6'd24,
   parameter logic [4:0] B_MAX = 5'd12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [11:0] end_addr,
   output logic        rd_en,
   output logic [11:0] rd_addr,
   input  logic [15:0] rd_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_pix,
   output logic [4:0]  out_r,
   output logic [5:0]  out_g,
   output logic [4:0]  out_b,
   output logic        out_hit,
   output logic [11:0] out_idx,
   output logic        out_last,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam int         DEPTH   = 4;

   logic [1:0]       state_q, state_d;
   logic [11:0]      end_q, end_d;
   logic [11:0]      addr_q, addr_d;
   logic             done_q, done_d;
   logic             rvld_q;
   logic [11:0]      ridx_q;

   logic [15:0]      pix_q [DEPTH];
   logic [11:0]      idx_q [DEPTH];
   logic [DEPTH-1:0] last_q;
   logic [DEPTH-1:0] wr_sel;
   logic [1:0]       wptr_q, wptr_d;
   logic [1:0]       rptr_q, rptr_d;
   logic [2:0]       count_q, count_d;

   logic [3:0]       credit_used;
   logic             issue;
   logic             push;
   logic             pop;

   // Words already buffered plus the one returning from the RAM this cycle must leave
   // room for another read, so the FIFO can never overflow.
   assign credit_used = {1'b0, count_q} + {3'b000, rvld_q};
   assign issue       = (state_q == S_READ) && (credit_used < 4'd4);
   assign push        = rvld_q;
   assign pop         = out_valid && out_ready;

   assign rd_en   = issue;
   assign rd_addr = addr_q;

   // ------------------------------------------------------------------ control FSM
   always_comb begin
      state_d = state_q;
      end_d   = end_q;
      addr_d  = addr_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               end_d = end_addr;
               if (end_addr == 12'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_READ;
                  addr_d  = 12'd1;
               end
            end
         end
         S_READ: begin
            // Address holds at end_addr after the final issue so it never wraps to 0.
            if (issue) begin
               if (addr_q == end_q) begin
                  state_d = S_DRAIN;
               end else begin
                  addr_d = addr_q + 12'd1;
               end
            end
         end
         S_DRAIN: begin
            if (pop && out_last) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         end_q   <= 12'd0;
         addr_q  <= 12'd0;
         done_q  <= 1'b0;
         rvld_q  <= 1'b0;
         ridx_q  <= 12'd0;
      end else begin
         state_q <= state_d;
         end_q   <= end_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
         rvld_q  <= issue;
         if (issue) begin
            ridx_q <= addr_q;
         end
      end
   end

   // ------------------------------------------------------------------ output FIFO
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
         assign wr_sel[gi] = push && (wptr_q == 2'(gi));
      end
   endgenerate

   always_comb begin
      wptr_d  = push ? wptr_q + 2'd1 : wptr_q;
      rptr_d  = pop  ? rptr_q + 2'd1 : rptr_q;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= 2'd0;
         rptr_q  <= 2'd0;
         count_q <= 3'd0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Payload storage needs no reset: entries are only visible while count_q covers them.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_sel[i]) begin
            pix_q[i]  <= rd_data;
            idx_q[i]  <= ridx_q;
            last_q[i] <= (ridx_q == end_q);
         end
      end
   end

   assign out_valid = (count_q != 3'd0);
   assign out_pix   = pix_q[rptr_q];
   assign out_idx   = idx_q[rptr_q];
   assign out_last  = last_q[rptr_q];
   assign out_r     = out_pix[15:11];
   assign out_g     = out_pix[10:5];
   assign out_b     = out_pix[4:0];
   assign out_hit   = (out_r >= R_MIN) && (out_g <= G_MAX) && (out_b <= B_MAX);

   assign busy = (state_q != S_IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_pixread.sv
// Bench for pixread: a behavioural RAM plus an expected-word queue built from the buffer
// contents; every handshake, address and status output is compared cycle by cycle.
module tb_pixread;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [11:0] end_addr = 12'd0;
   logic        rd_en;
   logic [11:0] rd_addr;
   logic [15:0] rd_data = 16'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_pix;
   logic [4:0]  out_r;
   logic [5:0]  out_g;
   logic [4:0]  out_b;
   logic        out_hit;
   logic [11:0] out_idx;
   logic        out_last;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [4096];

   typedef struct {
      logic [15:0] pix;
      logic [11:0] idx;
      logic        last;
   } exp_t;

   pixread dut (
      .clk(clk), .rst(rst), .start(start), .end_addr(end_addr),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
      .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_hit(out_hit),
      .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Synchronous-read line buffer
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_hit(input logic [15:0] w);
      int r, g, b;
      r = int'(w) / 2048;
      g = (int'(w) / 32) % 64;
      b = int'(w) % 32;
      return (r >= 20) && (g <= 24) && (b <= 12);
   endfunction

   // One read-out: start in the current cycle, then step until done (or stop early after
   // stop_after accepted words). Returns with the clock just past an edge (+1).
   task automatic run(input int ea, input int ready_pct, input int second_k, input int stop_after,
                      output int first_valid_k, output int first_acc_k, output int last_acc_k);
      exp_t q[$];
      exp_t e;
      int   issued, accepted;
      bit   finished;
      logic exp_done, exp_busy;
      for (int a = 1; a <= ea; a++) begin
         e.pix  = mem[a];
         e.idx  = 12'(a);
         e.last = (a == ea);
         q.push_back(e);
      end
      first_valid_k = -1;
      first_acc_k   = -1;
      last_acc_k    = -1;
      issued        = 0;
      accepted      = 0;
      finished      = 0;
      start    = 1'b1;
      end_addr = 12'(ea);
      @(posedge clk); #1;
      start    = 1'b0;
      end_addr = 12'($urandom);
      for (int k = 1; k <= ea * 8 + 50 && !finished; k++) begin
         out_ready = ($urandom_range(99) < ready_pct);
         if (k == second_k) begin
            start    = 1'b1;
            end_addr = 12'(ea / 3 + 1);
         end else begin
            start = 1'b0;
         end
         exp_done = (ea == 0) ? (k == 1) : (accepted == ea && k == last_acc_k + 1);
         exp_busy = (ea != 0) && (accepted != ea);
         chk("done", done, exp_done);
         chk("busy", busy, exp_busy);
         if (rd_en) begin
            issued++;
            chk("rd_addr", rd_addr, issued);
            chk("issue_within_end", issued <= ea, 1);
            chk("outstanding_le4", (issued - accepted) <= 4, 1);
         end
         if (out_valid && first_valid_k < 0) first_valid_k = k;
         if (out_valid && out_ready) begin
            chk("word_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("out_pix",  out_pix,  e.pix);
               chk("out_idx",  out_idx,  e.idx);
               chk("out_last", out_last, e.last);
               chk("out_r",    out_r,    int'(e.pix) / 2048);
               chk("out_g",    out_g,    (int'(e.pix) / 32) % 64);
               chk("out_b",    out_b,    int'(e.pix) % 32);
               chk("out_hit",  out_hit,  model_hit(e.pix));
               $display("word idx=%0d pix=%04h hit=%0b last=%0b k=%0d", out_idx, out_pix, out_hit, out_last, k);
               accepted++;
               if (first_acc_k < 0) first_acc_k = k;
               last_acc_k = k;
            end
         end
         if (done || exp_done) finished = 1;
         if (stop_after >= 0 && accepted == stop_after) finished = 1;
         if (!finished) begin
            @(posedge clk); #1;
         end
      end
      chk("completed", finished, 1);
      if (stop_after < 0) begin
         chk("all_accepted", accepted, ea);
         chk("all_issued", issued, ea);
      end
      start = 1'b0;
   endtask

   initial begin
      int fv, fa, la;
      for (int a = 0; a < 4096; a++) mem[a] = 16'($urandom);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: five words, ready always high
      for (int a = 1; a <= 5; a++) mem[a] = 16'(a * 16'h1111);
      run(5, 100, -1, -1, fv, fa, la);
      chk("t1_first_valid", fv, 3);
      chk("t1_first_accept", fa, 3);
      chk("t1_back_to_back", la - fa, 4);
      @(posedge clk); #1;

      // 2: 100 words, random backpressure
      for (int a = 1; a <= 100; a++) mem[a] = 16'($urandom);
      run(100, 50, -1, -1, fv, fa, la);
      @(posedge clk); #1;

      // 3: empty buffer
      run(0, 100, -1, -1, fv, fa, la);
      chk("t3_no_valid", fv, -1);
      @(posedge clk); #1;

      // 4: colour threshold edges
      mem[1] = 16'hA000;
      mem[2] = 16'h9800;
      mem[3] = 16'hA320;
      mem[4] = 16'hA30C;
      mem[5] = 16'hA30D;
      run(5, 100, -1, -1, fv, fa, la);
      @(posedge clk); #1;

      // 5: start while busy is ignored
      for (int a = 1; a <= 20; a++) mem[a] = 16'($urandom);
      run(20, 100, 5, -1, fv, fa, la);
      @(posedge clk); #1;

      // 6: reset after 3 of 10 words, then a fresh 2-word read
      run(10, 100, -1, 3, fv, fa, la);
      @(posedge clk); #1;
      rst       = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t6_out_valid", out_valid, 0);
      chk("t6_busy", busy, 0);
      chk("t6_rd_en", rd_en, 0);
      chk("t6_done", done, 0);
      run(2, 100, -1, -1, fv, fa, la);
      @(posedge clk); #1;

      // Random lengths and ready rates
      for (int t = 0; t < 3; t++) begin
         int n;
         n = $urandom_range(40, 1);
         for (int a = 1; a <= n; a++) mem[a] = 16'($urandom);
         run(n, $urandom_range(90, 20), -1, -1, fv, fa, la);
         @(posedge clk); #1;
      end

      // Full buffer: 1..4095 with no wrap
      for (int a = 1; a < 4096; a++) mem[a] = 16'($urandom);
      run(4095, 100, -1, -1, fv, fa, la);
      chk("full_back_to_back", la - fa, 4094);
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
